game_sequencer: RTL

Round controller for the reaction game. Arms the hit checker each round with a pseudo-random target lane, runs the per-round reaction timer, tallies points and lives from the checker's result flags, and ends the game when lives reach zero. Sits between the player start key, the four lane buttons and the hit-check datapath; drives its `random_num`, `start_checks` and `clock_done` inputs.

---
 rtl/game_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: round controller for the reaction game.
// Arms the hit checker with a pseudo-random lane, times each round,
// tallies score/lives from the checker flags and ends the game at zero lives.
// Optional feature macro: GAME_SEQ_NO_REPEAT_EN (consecutive targets always differ).
//
// Checker interface: start_checks is the enable for the hit checker and is high
// exactly during ARMED; give_point/lose_point are level flags sampled every ARMED
// clock except the first, which still carries the previous round's result.
module game_sequencer #(
    parameter int ROUND_TICKS = 50_000_000,
    parameter int GAP_TICKS   = 12_500_000,
    parameter int LIVES       = 3,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_n,
    input  logic [3:0]         buttons_n,
    input  logic               give_point,
    input  logic               lose_point,
    output logic [1:0]         random_num,
    output logic               start_checks,
    output logic               clock_done,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               game_over,
    output logic [2:0]         o_dbg_state
);

    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int TW = $clog2(ROUND_TICKS);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ROUND_TICKS - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
    localparam logic [15:0]   LFSR_SEED  = 16'hACE1;
    localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_ARMED  = 3'd2,
        S_SETTLE = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_nxt;
    logic                r_start_prev;
    logic                w_start_fall;
    logic [GW-1:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [1:0]          r_random_num, w_random_nxt;
    logic [1:0]          w_pick;
    logic [SCORE_W-1:0]  r_score, w_score_nxt;
    logic [2:0]          r_lives, w_lives_nxt;
    logic                r_start_checks;
    logic                r_clock_done;
    logic                r_game_over;

    // Galois LFSR step; the seed is non-zero so the sequence never locks up.
    assign w_lfsr_nxt   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    // Start key press: previous sample high, current sample low.
    assign w_start_fall = r_start_prev & ~start_n;

    // Target lane selection at GAP exit.
    always_comb begin
        w_pick = r_lfsr[1:0];
`ifdef GAME_SEQ_NO_REPEAT_EN
        if (w_pick == r_random_num) begin
            w_pick = w_pick + 2'd1;
        end
`endif
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_timer_nxt   = r_timer;
        w_random_nxt  = r_random_num;
        w_score_nxt   = r_score;
        w_lives_nxt   = r_lives;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_fall) begin
                    w_score_nxt   = '0;
                    w_lives_nxt   = LIVES_INIT;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    // Counter holds at its last value while a button is still down.
                    if (buttons_n == 4'b1111) begin
                        w_random_nxt = w_pick;
                        w_timer_nxt  = '0;
                        w_state_nxt  = S_ARMED;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GW'(1);
                end
            end
            S_ARMED: begin
                if (r_timer != TIMER_LAST) begin
                    w_timer_nxt = r_timer + TW'(1);
                end
                // Timer value 0 marks the first ARMED clock, whose flags are stale.
                if (r_timer != '0) begin
                    if (give_point) begin
                        if (r_score != '1) begin
                            w_score_nxt = r_score + SCORE_W'(1);
                        end
                        w_state_nxt = S_SETTLE;
                    end else if (lose_point) begin
                        if (r_lives != 3'd0) begin
                            w_lives_nxt = r_lives - 3'd1;
                        end
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_lives == 3'd0) begin
                    w_state_nxt = S_OVER;
                end else begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs, derived from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr         <= LFSR_SEED;
            r_start_prev   <= 1'b1;
            r_gap_cnt      <= '0;
            r_timer        <= '0;
            r_random_num   <= 2'd0;
            r_score        <= '0;
            r_lives        <= LIVES_INIT;
            r_start_checks <= 1'b0;
            r_clock_done   <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_lfsr         <= w_lfsr_nxt;
            r_start_prev   <= start_n;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_timer        <= w_timer_nxt;
            r_random_num   <= w_random_nxt;
            r_score        <= w_score_nxt;
            r_lives        <= w_lives_nxt;
            r_start_checks <= (w_state_nxt == S_ARMED);
            r_clock_done   <= (w_state_nxt == S_ARMED) && (w_timer_nxt == TIMER_LAST);
            r_game_over    <= (w_state_nxt == S_OVER);
        end
    end

    assign random_num   = r_random_num;
    assign start_checks = r_start_checks;
    assign clock_done   = r_clock_done;
    assign score        = r_score;
    assign lives        = r_lives;
    assign game_over    = r_game_over;
    assign o_dbg_state  = r_state;

endmodule
